// File: rtl/fnd_scan_driver.sv
// Four-digit multiplexed seven-segment scan driver with per-frame input snapshot,
// per-digit blink and leading-zero suppression; seg and com are registered.
module fnd_scan_driver #(
   parameter int unsigned SCAN_DIV       = 50000,
   parameter int unsigned DEAD           = 500,
   parameter int unsigned BLINK_DIV      = 100,
   parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] d0,
   input  logic [3:0] d1,
   input  logic [3:0] d2,
   input  logic [3:0] d3,
   input  logic [3:0] blink_en,
   input  logic       lz_en,
   output logic [6:0] seg,
   output logic [3:0] com
);

   localparam int unsigned PW        = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int unsigned BW        = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   localparam logic [3:0]  CODE_BLK  = 4'd10;
   localparam logic [6:0]  SEG_BLANK = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;

   logic [PW-1:0]   pcnt_q, pcnt_d;
   logic [1:0]      idx_q, idx_d;
   logic [BW-1:0]   bcnt_q, bcnt_d;
   logic            bph_q, bph_d;
   logic [3:0][3:0] sh_dig_q;
   logic [3:0]      sh_blink_q;
   logic            sh_lz_q;
   logic [6:0]      seg_q, seg_d;
   logic [3:0]      com_q, com_d;

   logic            tick_c;
   logic            load_c;
   logic            dead_c;
   logic [3:0]      zblk_c;
   logic [3:0]      lz_c;
   logic [3:0]      code_c;
   logic [6:0]      pat_c;

   function automatic logic [6:0] seg_pattern(input logic [3:0] code);
      logic [6:0] p;
      case (code)
         4'd0:    p = 7'h3F;
         4'd1:    p = 7'h06;
         4'd2:    p = 7'h5B;
         4'd3:    p = 7'h4F;
         4'd4:    p = 7'h66;
         4'd5:    p = 7'h6D;
         4'd6:    p = 7'h7D;
         4'd7:    p = 7'h07;
         4'd8:    p = 7'h7F;
         4'd9:    p = 7'h6F;
         4'd11:   p = 7'h40;
         default: p = 7'h00;
      endcase
      return p;
   endfunction

   // Timebase: prescaler, slot index, blink phase and frame-end snapshot strobe
   always_comb begin
      tick_c = (pcnt_q == PW'(SCAN_DIV - 1));
      load_c = tick_c && (idx_q == 2'd3);
      pcnt_d = tick_c ? '0 : pcnt_q + PW'(1);
      idx_d  = tick_c ? idx_q + 2'd1 : idx_q;
      bcnt_d = bcnt_q;
      bph_d  = bph_q;
      if (tick_c) begin
         if (bcnt_q == BW'(BLINK_DIV - 1)) begin
            bcnt_d = '0;
            bph_d  = ~bph_q;
         end else begin
            bcnt_d = bcnt_q + BW'(1);
         end
      end
   end

   // Digit selection with blink taking priority over leading-zero blanking
   always_comb begin
      for (int i = 0; i < 4; i++) begin
         zblk_c[i] = (sh_dig_q[i] == 4'd0) || (sh_dig_q[i] == CODE_BLK);
      end
      lz_c    = '0;
      lz_c[3] = sh_lz_q && (sh_dig_q[3] == 4'd0);
      lz_c[2] = sh_lz_q && (sh_dig_q[2] == 4'd0) && zblk_c[3];
      lz_c[1] = sh_lz_q && (sh_dig_q[1] == 4'd0) && zblk_c[3] && zblk_c[2];

      code_c = sh_dig_q[idx_q];
      if (sh_blink_q[idx_q] && bph_q) begin
         code_c = CODE_BLK;
      end else if (lz_c[idx_q]) begin
         code_c = CODE_BLK;
      end

      dead_c = (pcnt_q < PW'(DEAD));
      pat_c  = seg_pattern(code_c);
      com_d  = ~(4'b0001 << idx_q);
      if (dead_c) begin
         pat_c = 7'h00;
         com_d = 4'hF;
      end
      seg_d = SEG_ACTIVE_LOW ? ~pat_c : pat_c;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pcnt_q     <= '0;
         idx_q      <= '0;
         bcnt_q     <= '0;
         bph_q      <= 1'b0;
         sh_dig_q   <= {4{CODE_BLK}};
         sh_blink_q <= '0;
         sh_lz_q    <= 1'b0;
         seg_q      <= SEG_BLANK;
         com_q      <= 4'hF;
      end else begin
         pcnt_q <= pcnt_d;
         idx_q  <= idx_d;
         bcnt_q <= bcnt_d;
         bph_q  <= bph_d;
         seg_q  <= seg_d;
         com_q  <= com_d;
         if (load_c) begin
            sh_dig_q   <= {d3, d2, d1, d0};
            sh_blink_q <= blink_en;
            sh_lz_q    <= lz_en;
         end
      end
   end

   assign seg = seg_q;
   assign com = com_q;

endmodule

// File: tb/tb_fnd_scan_driver.sv
// Directed bench for fnd_scan_driver: two instances (active-low and active-high
// segments) share one stimulus; SCAN_DIV=4, DEAD=1, BLINK_DIV=2.
module tb_fnd_scan_driver;

   logic       clk;
   logic       rst_n;
   logic [3:0] d0, d1, d2, d3;
   logic [3:0] blink_en;
   logic       lz_en;
   logic [6:0] seg_lo, seg_hi;
   logic [3:0] com_lo, com_hi;

   int vectors;
   int miscompares;
   int cyc;

   fnd_scan_driver #(
      .SCAN_DIV(4), .DEAD(1), .BLINK_DIV(2), .SEG_ACTIVE_LOW(1'b1)
   ) dut_lo (
      .clk(clk), .rst_n(rst_n), .d0(d0), .d1(d1), .d2(d2), .d3(d3),
      .blink_en(blink_en), .lz_en(lz_en), .seg(seg_lo), .com(com_lo)
   );

   fnd_scan_driver #(
      .SCAN_DIV(4), .DEAD(1), .BLINK_DIV(2), .SEG_ACTIVE_LOW(1'b0)
   ) dut_hi (
      .clk(clk), .rst_n(rst_n), .d0(d0), .d1(d1), .d2(d2), .d3(d3),
      .blink_en(blink_en), .lz_en(lz_en), .seg(seg_hi), .com(com_hi)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic clk1();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic run_frame();
      repeat (16) clk1();
   endtask

   // One 16-cycle frame from a frame boundary: per slot one dead cycle then three lit cycles
   task automatic check_frame(input string nm,
                              input logic [6:0] e0, input logic [6:0] e1,
                              input logic [6:0] e2, input logic [6:0] e3,
                              input int chg_slot = -1, input logic [3:0] chg_val = 4'd0);
      logic [6:0] ex [4];
      logic [6:0] es;
      logic [3:0] ecom;
      ex[0] = e0; ex[1] = e1; ex[2] = e2; ex[3] = e3;
      for (int k = 0; k < 4; k++) begin
         if (k == chg_slot) d1 = chg_val;
         for (int c = 0; c < 4; c++) begin
            clk1();
            ecom = (c == 0) ? 4'hF : ~(4'b0001 << k);
            es   = (c == 0) ? 7'h00 : ex[k];
            vectors++;
            if (com_lo !== ecom || com_hi !== ecom) begin
               miscompares++;
               $display("FAIL %s com slot%0d cyc%0d: got %b/%b expected %b",
                        nm, k, c, com_lo, com_hi, ecom);
            end
            vectors++;
            if (seg_hi !== es || seg_lo !== ~es) begin
               miscompares++;
               $display("FAIL %s seg slot%0d cyc%0d: got hi=%h lo=%h expected hi=%h lo=%h",
                        nm, k, c, seg_hi, seg_lo, es, ~es);
            end
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      d0 = 4'd4; d1 = 4'd3; d2 = 4'd2; d3 = 4'd1;
      blink_en = 4'b0000; lz_en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         clk1();
         vectors++;
         if (com_lo !== 4'hF || com_hi !== 4'hF || seg_lo !== 7'h7F || seg_hi !== 7'h00) begin
            miscompares++;
            $display("FAIL reset_hold cyc%0d: got com=%b/%b seg lo=%h hi=%h expected 1111 7f 00",
                     i, com_lo, com_hi, seg_lo, seg_hi);
         end
      end
      rst_n = 1'b1;
      cyc = 0;
      check_frame("first_frame_blank", 7'h00, 7'h00, 7'h00, 7'h00);
   endtask

   task automatic test_scan_order();
      check_frame("scan_order", 7'h66, 7'h4F, 7'h5B, 7'h06);
   endtask

   task automatic test_snapshot();
      d0 = 4'd0; d1 = 4'd5; d2 = 4'd0; d3 = 4'd0;
      run_frame();
      check_frame("snap_hold", 7'h3F, 7'h6D, 7'h3F, 7'h3F, 1, 4'd9);
      check_frame("snap_new", 7'h3F, 7'h6F, 7'h3F, 7'h3F);
   endtask

   task automatic test_leading_zero();
      lz_en = 1'b1;
      d0 = 4'd0; d1 = 4'd0; d2 = 4'd0; d3 = 4'd0;
      run_frame();
      check_frame("lz_all_zero", 7'h3F, 7'h00, 7'h00, 7'h00);
      d0 = 4'd7; d1 = 4'd0; d2 = 4'd1; d3 = 4'd0;
      run_frame();
      check_frame("lz_inner_zero", 7'h07, 7'h3F, 7'h06, 7'h00);
      lz_en = 1'b0;
   endtask

   // Blink phase is high for the second half of every frame at these parameters
   task automatic test_blink();
      d0 = 4'd8; d1 = 4'd8; d2 = 4'd8; d3 = 4'd8;
      blink_en = 4'b0001;
      run_frame();
      check_frame("blink_d0_only", 7'h7F, 7'h7F, 7'h7F, 7'h7F);
      blink_en = 4'b1111;
      run_frame();
      check_frame("blink_all", 7'h7F, 7'h7F, 7'h00, 7'h00);
      blink_en = 4'b0100;
      run_frame();
      check_frame("blink_d2", 7'h7F, 7'h7F, 7'h00, 7'h7F);
      blink_en = 4'b0000;
   endtask

   task automatic test_code_map();
      d0 = 4'd10; d1 = 4'd11; d2 = 4'd12; d3 = 4'd13;
      run_frame();
      check_frame("codes_10_13", 7'h00, 7'h40, 7'h00, 7'h00);
      d0 = 4'd14; d1 = 4'd15; d2 = 4'd11; d3 = 4'd10;
      run_frame();
      check_frame("codes_14_15", 7'h00, 7'h00, 7'h40, 7'h00);
   endtask

   task automatic test_reset_mid_frame();
      d0 = 4'd4; d1 = 4'd3; d2 = 4'd2; d3 = 4'd1;
      repeat (6) clk1();
      rst_n = 1'b0;
      for (int i = 0; i < 2; i++) begin
         clk1();
         vectors++;
         if (com_lo !== 4'hF || com_hi !== 4'hF || seg_lo !== 7'h7F || seg_hi !== 7'h00) begin
            miscompares++;
            $display("FAIL reset_mid cyc%0d: got com=%b/%b seg lo=%h hi=%h expected 1111 7f 00",
                     i, com_lo, com_hi, seg_lo, seg_hi);
         end
      end
      rst_n = 1'b1;
      cyc = 0;
      check_frame("post_reset_blank", 7'h00, 7'h00, 7'h00, 7'h00);
      check_frame("post_reset_scan", 7'h66, 7'h4F, 7'h5B, 7'h06);
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      cyc         = 0;
      test_reset();
      test_scan_order();
      test_snapshot();
      test_leading_zero();
      test_blink();
      test_code_map();
      test_reset_mid_frame();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
